checksum_entry: RTL

CHECKSUM_ENTRY -- requirements
Module: checksum_entry

---
 rtl/checksum_pkg.sv | 16 +
 rtl/edge_detect.sv | 26 ++
 rtl/checksum_entry.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/checksum_pkg.sv
// Shared types and sizing for the checksum entry block.
package checksum_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned CNT_W         = 3;
    localparam int unsigned BYTE_W        = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        CALC  = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse from a debounced button level; a level held through reset
// produces no pulse because the previous level resets high.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in;
        pulse  = in & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/checksum_entry.sv
// Button-driven byte entry with a ones-complement checksum computed one byte
// per cycle over the stored bytes.
module checksum_entry
    import checksum_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             butLoad,
    input  logic             butCalc,
    input  logic             butClear,
    input  logic [7:0]       sw,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             busy,
    output logic             done,
    output logic [7:0]       checksum
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic load_ev;
    logic calc_ev;
    logic clear_ev;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    byte_t            acc_q, acc_d;
    byte_t            checksum_q, checksum_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    byte_t            mem_q [DEPTH];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    byte_t            rd_byte;
    logic [8:0]       sum9;
    byte_t            acc_new;
    logic             can_load;
    logic             can_calc;
    logic             last_idx;

    edge_detect u_edge_load  (.clk(clk), .reset(reset), .in(butLoad),  .pulse(load_ev));
    edge_detect u_edge_calc  (.clk(clk), .reset(reset), .in(butCalc),  .pulse(calc_ev));
    edge_detect u_edge_clear (.clk(clk), .reset(reset), .in(butClear), .pulse(clear_ev));

    // Shared decode used by both next-state and datapath logic.
    always_comb begin
        can_load = (count_q < CNT_W'(DEPTH));
        can_calc = (count_q != '0);
        last_idx = (idx_q == count_q - CNT_W'(1));
        rd_byte  = mem_q[IDX_W'(idx_q)];
        sum9     = {1'b0, acc_q} + {1'b0, rd_byte};
        acc_new  = sum9[7:0] + BYTE_W'(sum9[8]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats calc beats load.
    always_comb begin
        state_d = state_q;
        if (clear_ev) begin
            state_d = ENTRY;
        end else begin
            unique case (state_q)
                ENTRY:   if (calc_ev && can_calc) state_d = CALC;
                CALC:    if (last_idx) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = ENTRY;
            endcase
        end
    end

    always_comb begin
        count_d    = count_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        checksum_d = checksum_q;
        mem_we     = 1'b0;
        mem_waddr  = IDX_W'(count_q);
        if (clear_ev) begin
            count_d    = '0;
            checksum_d = '0;
        end else begin
            unique case (state_q)
                ENTRY: begin
                    if (calc_ev) begin
                        if (can_calc) begin
                            idx_d = '0;
                            acc_d = '0;
                        end
                    end else if (load_ev && can_load) begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                CALC: begin
                    acc_d = acc_new;
                    idx_d = idx_q + CNT_W'(1);
                    if (last_idx) begin
                        checksum_d = ~acc_new;
                    end
                end
                default: ;
            endcase
        end
        full_d = (count_d == CNT_W'(DEPTH));
        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            checksum_q <= '0;
            full_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
            full_q     <= full_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Byte storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= sw;
        end
    end

    assign count    = count_q;
    assign full     = full_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;

endmodule
